// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment scan driver: double-buffered hex frame, per-digit
// decimal point / blank, leading-zero suppression and anti-ghosting blank slots.
module sseg_scan_driver #(
    parameter int DIGITS             = 4,
    parameter int REFRESH_DIV        = 50000,
    parameter int BLANK_CYCLES       = 2,
    parameter int CATHODE_ACTIVE_LOW = 0,
    parameter int ANODE_ACTIVE_LOW   = 1,
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Nums,
    input  logic [DIGITS-1:0]     DpIn,
    input  logic [DIGITS-1:0]     BlankIn,
    input  logic                  LzSuppress,
    output logic [7:0]            Cathode,
    output logic [DIGITS-1:0]     Anode,
    output logic [DW-1:0]         Digit,
    output logic                  Frame
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]     CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0]     DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [7:0]        CATH_OFF   = (CATHODE_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF     = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CW-1:0]       cnt;
    logic [DW-1:0]       digit;
    logic                slot_end;
    logic                wrap;

    logic [4*DIGITS-1:0] disp_nums;
    logic [DIGITS-1:0]   disp_dp;
    logic [DIGITS-1:0]   disp_blank;
    logic [4*DIGITS-1:0] pend_nums;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_blank;
    logic                pend_valid;

    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                cur_lz;
    logic                in_blank;
    logic                lit;
    logic [DIGITS-1:0]   onehot;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end = Enable && (cnt == CNT_LAST);
    assign wrap     = slot_end && (digit == DIGIT_LAST);
    // Frame flags the cycle whose clock edge moves Digit back to 0, so a Load
    // seen together with Frame lands directly in the display register.
    assign Frame    = wrap;
    assign Digit    = digit;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt   <= '0;
            digit <= '0;
        end else if (Enable) begin
            if (slot_end) begin
                cnt   <= '0;
                digit <= (digit == DIGIT_LAST) ? '0 : digit + DW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            disp_nums  <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            pend_nums  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (Load) begin
                pend_nums  <= Nums;
                pend_dp    <= DpIn;
                pend_blank <= BlankIn;
            end
            if (wrap && Load) begin
                disp_nums  <= Nums;
                disp_dp    <= DpIn;
                disp_blank <= BlankIn;
                pend_valid <= 1'b0;
            end else if (wrap && pend_valid) begin
                disp_nums  <= pend_nums;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
                pend_valid <= 1'b0;
            end else if (Load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // A digit is suppressed when it and every more-significant digit are zero.
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        onehot    = '0;
        cur_lz    = LzSuppress && (digit != '0);
        for (int unsigned k = 0; k < DIGITS; k++) begin
            onehot[k] = (DW'(k) == digit);
            if (DW'(k) == digit) begin
                cur_nib   = disp_nums[4*k +: 4];
                cur_dp    = disp_dp[k];
                cur_blank = disp_blank[k];
            end
            if ((DW'(k) >= digit) && (disp_nums[4*k +: 4] != 4'h0)) begin
                cur_lz = 1'b0;
            end
        end
        in_blank = int'(cnt) < BLANK_CYCLES;
        lit      = Enable && !in_blank && !cur_blank && !cur_lz;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Cathode <= CATH_OFF;
            Anode   <= AN_OFF;
        end else if (lit) begin
            Cathode <= {cur_dp, seg7(cur_nib)} ^ CATH_OFF;
            Anode   <= onehot ^ AN_OFF;
        end else begin
            Cathode <= CATH_OFF;
            Anode   <= AN_OFF;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: frame-position reference model checked every
// cycle, plus directed scenarios with hand-computed segment values.
module tb_sseg_scan_driver;

    localparam int D  = 4;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int FL = D * RD;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Enable = 1'b0;
    logic        Load = 1'b0;
    logic        LzSuppress = 1'b0;
    logic [15:0] Nums = '0;
    logic [3:0]  DpIn = '0;
    logic [3:0]  BlankIn = '0;
    logic [7:0]  Cathode;
    logic [3:0]  Anode;
    logic [1:0]  Digit;
    logic        Frame;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    sseg_scan_driver #(
        .DIGITS(D),
        .REFRESH_DIV(RD),
        .BLANK_CYCLES(BC),
        .CATHODE_ACTIVE_LOW(0),
        .ANODE_ACTIVE_LOW(1)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Enable(Enable),
        .Load(Load),
        .Nums(Nums),
        .DpIn(DpIn),
        .BlankIn(BlankIn),
        .LzSuppress(LzSuppress),
        .Cathode(Cathode),
        .Anode(Anode),
        .Digit(Digit),
        .Frame(Frame)
    );

    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait timed out (t=%0t)", name, $time);
    endtask

    // Model: scan position within the frame as one integer, buffers as vectors.
    int          pos = 0;
    logic [15:0] dn = '0, pn = '0;
    logic [3:0]  ddp = '0, pdp = '0, dbl = '0, pbl = '0;
    bit          pv = 1'b0;

    initial begin : model
        int d, c;
        bit lit, wrap;
        logic [3:0] nib, ea;
        logic [7:0] ec;
        forever begin
            @(posedge Clk);
            if (Reset) begin
                pos = 0; dn = '0; pn = '0; ddp = '0; pdp = '0; dbl = '0; pbl = '0; pv = 1'b0;
                continue;
            end
            d   = pos / RD;
            c   = pos % RD;
            nib = 4'((dn >> (4 * d)) & 16'hF);
            lit = Enable && (c >= BC) && !dbl[d] && !(LzSuppress && d > 0 && (dn >> (4 * d)) == 16'h0);
            ea  = lit ? ~(4'b0001 << d) : 4'hF;
            ec  = lit ? {ddp[d], segtab[nib]} : 8'h00;
            wrap = Enable && (pos == FL - 1);
            if (wrap && Load) begin
                dn = Nums; ddp = DpIn; dbl = BlankIn; pv = 1'b0;
            end else if (wrap && pv) begin
                dn = pn; ddp = pdp; dbl = pbl; pv = 1'b0;
            end else if (Load) begin
                pv = 1'b1;
            end
            if (Load) begin
                pn = Nums; pdp = DpIn; pbl = BlankIn;
            end
            if (Enable) pos = (pos + 1) % FL;
            #1;
            chk("anode", Anode, ea);
            chk("cathode", Cathode, ec);
            chk("digit", Digit, pos / RD);
            chk("frame", Frame, Enable && (pos == FL - 1));
        end
    end

    task automatic do_load(input logic [15:0] n, input logic [3:0] dp, input logic [3:0] bl);
        Nums = n; DpIn = dp; BlankIn = bl; Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (Frame) return;
        end
        timeout(name);
    endtask

    task automatic wait_digit(input logic [1:0] v, input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (Digit == v) return;
        end
        timeout(name);
    endtask

    task automatic wait_anode(input logic [3:0] an, input logic [7:0] cath, input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (Anode == an) begin
                chk(name, Cathode, cath);
                return;
            end
        end
        timeout(name);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        chk("rst_anode", Anode, 4'hF);
        chk("rst_cathode", Cathode, 8'h00);
        chk("rst_digit", Digit, 2'd0);
        chk("rst_frame", Frame, 1'b0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin : stim
        int bad, k;
        logic [15:0] n;
        #2;
        do_reset();

        // Basic frame: 4321, no dp
        Enable = 1'b1;
        do_load(16'h4321, 4'b0000, 4'b0000);
        wait_frame("b_frame", 40);
        wait_anode(4'b1110, 8'h06, "b_dig0", 10);
        wait_anode(4'b1011, 8'h4F, "b_dig2", 12);

        // Leading-zero suppression with dp on digit 0
        LzSuppress = 1'b1;
        do_load(16'h0004, 4'b0001, 4'b0000);
        wait_frame("c_frame", 40);
        wait_anode(4'b1110, 8'hE6, "c_dig0", 10);
        bad = 0;
        for (int i = 0; i < FL; i++) begin
            @(negedge Clk);
            if (Anode != 4'b1110 && Anode != 4'b1111) bad++;
        end
        chk("c_lz_dark", bad, 0);
        LzSuppress = 1'b0;
        wait_anode(4'b1101, 8'h3F, "c_nolz_dig1", 20);

        // Double load before wrap: last write wins, current frame untouched
        wait_digit(2'd1, "d_dig1", 40);
        do_load(16'hAAAA, 4'b0000, 4'b0000);
        wait_digit(2'd2, "d_dig2", 40);
        do_load(16'hBEEF, 4'b0000, 4'b0000);
        wait_anode(4'b0111, 8'h3F, "d_old_dig3", 12);
        wait_frame("d_frame", 40);
        wait_anode(4'b1110, 8'h71, "d_dig0_F", 10);
        wait_anode(4'b1101, 8'h79, "d_dig1_E", 10);
        wait_anode(4'b1011, 8'h79, "d_dig2_E", 10);
        wait_anode(4'b0111, 8'h7C, "d_dig3_b", 10);

        // Load in the Frame cycle goes straight to the display
        wait_frame("e_frame", 40);
        do_load(16'h1239, 4'b0000, 4'b0000);
        wait_anode(4'b1110, 8'h6F, "e_dig0_9", RD + 2);

        // Enable low mid digit 2
        wait_digit(2'd2, "f_dig2", 40);
        @(negedge Clk);
        Enable = 1'b0;
        repeat (10) @(negedge Clk);
        chk("f_hold_anode", Anode, 4'hF);
        chk("f_hold_cathode", Cathode, 8'h00);
        chk("f_hold_digit", Digit, 2'd2);
        Enable = 1'b1;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            if (Frame) begin
                k = i;
                break;
            end
        end
        chk("f_resume_frame", k, (RD - 2) + RD);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge Clk);
            Enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) LzSuppress = ~LzSuppress;
            for (int j = 0; j < 4; j++)
                n[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            Nums    = n;
            DpIn    = 4'($urandom);
            BlankIn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            Load    = ($urandom_range(0, 5) == 0);
        end
        @(negedge Clk);
        Load = 1'b0;
        Enable = 1'b1;
        LzSuppress = 1'b0;

        // Reset with a pending frame mid-scan
        wait_digit(2'd1, "h_dig1", 40);
        do_load(16'h7777, 4'b1111, 4'b0000);
        do_reset();
        wait_anode(4'b1110, 8'h3F, "h_dig0_zero", 12);
        repeat (FL) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
